// File: rtl/avl_wb_pkg.sv
// Shared types and constants for the Avalon-MM to Wishbone UART register bridge.
package avl_wb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // UART registers are byte wide and always sit in lane 0.
   localparam logic [3:0] WB_SEL = 4'b0001;

endpackage

// File: rtl/avl_wb_uart_bridge_if.sv
// Bus bundles for the bridge: Avalon-MM agent side and Wishbone classic host side.
interface avl_bus_if;
   logic [4:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic        avs_waitrequest;
   logic [31:0] avs_readdata;
   logic        avs_readdatavalid;
   logic [1:0]  avs_response;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      input  avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
   );
   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
      output avs_waitrequest, avs_readdata, avs_readdatavalid, avs_response
   );
endinterface

interface wb_bus_if;
   logic [2:0] wbm_adr_o;
   logic [7:0] wbm_dat_o;
   logic [7:0] wbm_dat_i;
   logic       wbm_we_o;
   logic       wbm_stb_o;
   logic       wbm_cyc_o;
   logic [3:0] wbm_sel_o;
   logic       wbm_ack_i;

   modport master (
      output wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_sel_o,
      input  wbm_dat_i, wbm_ack_i
   );
   modport slave (
      input  wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o, wbm_sel_o,
      output wbm_dat_i, wbm_ack_i
   );
endinterface

// File: rtl/avl_wb_uart_bridge.sv
// Avalon-MM agent to 8-bit Wishbone classic host; one transfer in flight, reads return 2+ cycles after accept.
// Stalls Avalon with waitrequest for the whole Wishbone cycle; writes are posted, a hung slave is abandoned after TIMEOUT_CYC.
module avl_wb_uart_bridge
   import avl_wb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] RD_ERR_DATA = 32'h0000_0000
) (
   input  logic     clk_riscv,
   input  logic     rst_in,
   avl_bus_if.slave avs,
   wb_bus_if.master wbm,
   output logic     timeout_o
);

   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

   state_e      state_q;
   logic        cyc_q;
   logic        we_q;
   logic [2:0]  adr_q;
   logic [7:0]  dat_q;
   logic        rdv_q;
   logic [1:0]  resp_q;
   logic [31:0] rdata_q;
   logic        to_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        unused_bits;

   assign cnt_d = cnt_q + 8'd1;

   always_ff @(posedge clk_riscv or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 3'd0;
         dat_q   <= 8'd0;
         rdv_q   <= 1'b0;
         resp_q  <= RESP_OKAY;
         rdata_q <= 32'd0;
         to_q    <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         rdv_q <= 1'b0;
         to_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // Write has priority over a simultaneous read; a write without lane 0 has nothing to do.
               if (avs.avs_write) begin
                  if (avs.avs_byteenable[0]) begin
                     state_q <= BUSY;
                     cyc_q   <= 1'b1;
                     we_q    <= 1'b1;
                     adr_q   <= avs.avs_address[4:2];
                     dat_q   <= avs.avs_writedata[7:0];
                     cnt_q   <= 8'd0;
                  end
               end else if (avs.avs_read) begin
                  state_q <= BUSY;
                  cyc_q   <= 1'b1;
                  we_q    <= 1'b0;
                  adr_q   <= avs.avs_address[4:2];
                  cnt_q   <= 8'd0;
               end
            end
            BUSY: begin
               if (wbm.wbm_ack_i) begin
                  state_q <= IDLE;
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  if (!we_q) begin
                     rdv_q   <= 1'b1;
                     resp_q  <= RESP_OKAY;
                     rdata_q <= {24'h0, wbm.wbm_dat_i};
                  end
               end else if (cnt_q == TO_LIMIT) begin
                  state_q <= IDLE;
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  to_q    <= 1'b1;
                  if (!we_q) begin
                     rdv_q   <= 1'b1;
                     resp_q  <= RESP_SLVERR;
                     rdata_q <= RD_ERR_DATA;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign avs.avs_waitrequest   = (state_q == BUSY);
   assign avs.avs_readdata      = rdata_q;
   assign avs.avs_readdatavalid = rdv_q;
   assign avs.avs_response      = resp_q;

   assign wbm.wbm_adr_o = adr_q;
   assign wbm.wbm_dat_o = dat_q;
   assign wbm.wbm_we_o  = we_q;
   assign wbm.wbm_stb_o = cyc_q;
   assign wbm.wbm_cyc_o = cyc_q;
   assign wbm.wbm_sel_o = WB_SEL;

   assign timeout_o = to_q;

   assign unused_bits = ^{avs.avs_address[1:0], avs.avs_writedata[31:8], avs.avs_byteenable[3:1]};

endmodule

// File: tb/tb_avl_wb_uart_bridge.sv
// Bench for avl_wb_uart_bridge: cycle tables for the directed cases plus random transfers against a transaction model.
module tb_avl_wb_uart_bridge;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_in = 1'b0;
   logic timeout;

   avl_bus_if avs_if();
   wb_bus_if  wb_if();

   avl_wb_uart_bridge #(.TIMEOUT_CYC(TO), .RD_ERR_DATA(32'h0000_0000)) dut (
      .clk_riscv (clk),
      .rst_in    (rst_in),
      .avs       (avs_if),
      .wbm       (wb_if),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rd, wr;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic        ack;
      logic [7:0]  dati;
      logic        e_busy, e_we;
      logic [2:0]  e_adr;
      logic [7:0]  e_dat;
      logic        e_rdv;
      logic [1:0]  e_resp;
      logic [31:0] e_rdata;
      logic        e_to;
   } vec_t;

   function automatic vec_t mk(logic rd, logic wr, logic [4:0] addr, logic [31:0] wdata, logic [3:0] be,
                               logic ack, logic [7:0] dati, logic busy, logic we, logic [2:0] adr,
                               logic [7:0] dat, logic rdv, logic [1:0] resp, logic [31:0] rdata, logic to);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.be = be; v.ack = ack; v.dati = dati;
      v.e_busy = busy; v.e_we = we; v.e_adr = adr; v.e_dat = dat;
      v.e_rdv = rdv; v.e_resp = resp; v.e_rdata = rdata; v.e_to = to;
      return v;
   endfunction

   // Idle cycle with optional ack noise and an expected completion result.
   function automatic vec_t idle(logic ack, logic [7:0] dati, logic rdv, logic [1:0] resp, logic [31:0] rdata, logic to);
      return mk(0, 0, 5'h0, 32'h0, 4'h0, ack, dati, 0, 0, 3'd0, 8'h0, rdv, resp, rdata, to);
   endfunction

   function automatic vec_t busy(logic ack, logic [7:0] dati, logic we, logic [2:0] adr, logic [7:0] dat);
      return mk(0, 0, 5'h0, 32'h0, 4'h0, ack, dati, 1, we, adr, dat, 0, 2'b00, 32'h0, 0);
   endfunction

   task automatic drive(vec_t v);
      avs_if.avs_read       = v.rd;
      avs_if.avs_write      = v.wr;
      avs_if.avs_address    = v.addr;
      avs_if.avs_writedata  = v.wdata;
      avs_if.avs_byteenable = v.be;
      wb_if.wbm_ack_i       = v.ack;
      wb_if.wbm_dat_i       = v.dati;
   endtask

   task automatic check_outs(string name, vec_t v);
      logic [50:0] act, exp;
      act = {avs_if.avs_waitrequest, wb_if.wbm_cyc_o, wb_if.wbm_stb_o, wb_if.wbm_we_o,
             v.e_busy ? wb_if.wbm_adr_o : 3'd0,
             (v.e_busy && v.e_we) ? wb_if.wbm_dat_o : 8'd0,
             avs_if.avs_readdatavalid,
             v.e_rdv ? avs_if.avs_response : 2'd0,
             v.e_rdv ? avs_if.avs_readdata : 32'd0,
             timeout};
      exp = {v.e_busy, v.e_busy, v.e_busy, v.e_busy & v.e_we,
             v.e_busy ? v.e_adr : 3'd0,
             (v.e_busy && v.e_we) ? v.e_dat : 8'd0,
             v.e_rdv,
             v.e_rdv ? v.e_resp : 2'd0,
             v.e_rdv ? v.e_rdata : 32'd0,
             v.e_to};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(string name, vec_t v);
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      check_outs(name, v);
   endtask

   task automatic check_reset_outs(string name);
      logic [50:0] act;
      act = {avs_if.avs_waitrequest, wb_if.wbm_cyc_o, wb_if.wbm_stb_o, wb_if.wbm_we_o, wb_if.wbm_adr_o,
             wb_if.wbm_dat_o, avs_if.avs_readdatavalid, avs_if.avs_response, avs_if.avs_readdata, timeout};
      n_checks++;
      if (act !== 51'd0) begin
         n_fail++;
         $display("FAIL %s: got %h expected all zero", name, act);
      end
   endtask

   task automatic expect_eq(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction-level model state: readdata holds the last completed read result.
   logic [31:0] last_rdata = 32'h0;

   task automatic run_txn(int idx);
      int          kind, d, exp_len, nbusy, n;
      logic        rd, wr, dropped, tmo, exp_rdv, stable;
      logic [4:0]  addr;
      logic [31:0] wd, exp_rdata;
      logic [3:0]  be;
      logic [7:0]  ack_dat;
      vec_t        req;

      kind = $urandom_range(0, 3);
      rd   = (kind != 2);
      wr   = (kind >= 2);
      addr = 5'($urandom);
      wd   = $urandom;
      be   = 4'($urandom);
      d    = $urandom_range(0, TO + 2);

      dropped   = wr && !be[0];
      tmo       = !dropped && (d > TO);
      exp_len   = dropped ? 0 : ((d <= TO) ? d + 1 : TO + 1);
      exp_rdv   = !wr;
      ack_dat   = 8'h0;

      req = mk(rd, wr, addr, wd, be, 1'($urandom), 8'($urandom), 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      @(posedge clk); #1;
      drive(req);
      @(negedge clk);
      expect_eq($sformatf("txn%0d_accept", idx), 64'(avs_if.avs_waitrequest), 64'd0);

      nbusy  = 0;
      stable = 1'b1;
      n      = 0;
      for (int guard = 0; guard < TO + 20; guard++) begin
         @(posedge clk); #1;
         avs_if.avs_read  = 1'b0;
         avs_if.avs_write = 1'b0;
         wb_if.wbm_ack_i  = (n == d);
         wb_if.wbm_dat_i  = 8'($urandom);
         if (n == d) ack_dat = wb_if.wbm_dat_i;
         @(negedge clk);
         if (!wb_if.wbm_cyc_o) break;
         nbusy++;
         if (!wb_if.wbm_stb_o || !avs_if.avs_waitrequest || wb_if.wbm_we_o !== wr ||
             wb_if.wbm_adr_o !== addr[4:2] || (wr && wb_if.wbm_dat_o !== wd[7:0]))
            stable = 1'b0;
         n++;
      end

      expect_eq($sformatf("txn%0d_len", idx), 64'(nbusy), 64'(exp_len));
      if (exp_len > 0)
         expect_eq($sformatf("txn%0d_bus", idx), 64'(stable), 64'd1);

      exp_rdata = exp_rdv ? (tmo ? 32'h0 : {24'h0, ack_dat}) : last_rdata;
      expect_eq($sformatf("txn%0d_done", idx),
                {29'd0, avs_if.avs_readdatavalid, timeout, exp_rdv ? avs_if.avs_response : 2'b00, avs_if.avs_readdata},
                {29'd0, exp_rdv, tmo, exp_rdv ? (tmo ? 2'b10 : 2'b00) : 2'b00, exp_rdata});
      last_rdata = exp_rdata;

      @(posedge clk); #1;
      wb_if.wbm_ack_i = 1'($urandom);
      @(negedge clk);
      expect_eq($sformatf("txn%0d_after", idx),
                {30'd0, avs_if.avs_readdatavalid, timeout, avs_if.avs_readdata},
                {30'd0, 1'b0, 1'b0, last_rdata});
   endtask

   vec_t tbl[21];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Read addr 0x14 acked in cycle 3.
      tbl[0]  = mk(1, 0, 5'h14, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[1]  = busy(0, 8'h00, 0, 3'd5, 8'h0);
      tbl[2]  = busy(0, 8'h00, 0, 3'd5, 8'h0);
      tbl[3]  = busy(1, 8'h60, 0, 3'd5, 8'h0);
      tbl[4]  = idle(0, 8'h00, 1, 2'b00, 32'h60, 0);
      // Posted write, acked in its first Wishbone cycle.
      tbl[5]  = mk(0, 1, 5'h00, 32'hA5, 4'h1, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[6]  = busy(1, 8'h00, 1, 3'd0, 8'hA5);
      tbl[7]  = idle(0, 8'h00, 0, 2'b00, 32'h0, 0);
      // Write without lane 0 is swallowed.
      tbl[8]  = mk(0, 1, 5'h08, 32'h33, 4'h2, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[9]  = idle(0, 8'h00, 0, 2'b00, 32'h0, 0);
      tbl[10] = idle(0, 8'h00, 0, 2'b00, 32'h0, 0);
      // Read+write together acts as a write, then a read lands in the ack+1 cycle.
      tbl[11] = mk(1, 1, 5'h0C, 32'h5A, 4'h1, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[12] = busy(1, 8'h00, 1, 3'd3, 8'h5A);
      tbl[13] = mk(1, 0, 5'h04, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[14] = busy(1, 8'hC3, 0, 3'd1, 8'h0);
      tbl[15] = idle(0, 8'h00, 1, 2'b00, 32'hC3, 0);
      // Stray acks while idle are ignored.
      tbl[16] = idle(1, 8'hFF, 0, 2'b00, 32'h0, 0);
      tbl[17] = idle(1, 8'hFF, 0, 2'b00, 32'h0, 0);
      // Minimum-latency read.
      tbl[18] = mk(1, 0, 5'h1C, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0);
      tbl[19] = busy(1, 8'h5E, 0, 3'd7, 8'h0);
      tbl[20] = idle(0, 8'h00, 1, 2'b00, 32'h5E, 0);

      drive(idle(0, 8'h00, 0, 2'b00, 32'h0, 0));
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outs("reset_state");
      expect_eq("wb_sel", 64'(wb_if.wbm_sel_o), 64'h1);

      // Release reset together with the first request: it must be taken on the first clean edge.
      @(posedge clk); #1;
      rst_in = 1'b1;
      drive(tbl[0]);
      @(negedge clk);
      check_outs("vec0", tbl[0]);
      for (int i = 1; i < 21; i++) step($sformatf("vec%0d", i), tbl[i]);

      // Read with no ack: abandoned after TO+1 busy cycles with SLVERR.
      step("to_rd_req", mk(1, 0, 5'h10, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0));
      for (int i = 0; i <= TO; i++) step($sformatf("to_rd_busy%0d", i), busy(0, 8'h00, 0, 3'd4, 8'h0));
      step("to_rd_done", idle(0, 8'h00, 1, 2'b10, 32'h0, 1));
      step("to_rd_after", idle(0, 8'h00, 0, 2'b00, 32'h0, 0));

      // Ack exactly at the threshold completes normally.
      step("thr_req", mk(1, 0, 5'h08, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0));
      for (int i = 0; i < TO; i++) step($sformatf("thr_busy%0d", i), busy(0, 8'h00, 0, 3'd2, 8'h0));
      step("thr_ack", busy(1, 8'h9C, 0, 3'd2, 8'h0));
      step("thr_done", idle(0, 8'h00, 1, 2'b00, 32'h9C, 0));

      // Timed-out write: pulse only, no read completion.
      step("to_wr_req", mk(0, 1, 5'h1C, 32'h77, 4'hF, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0));
      for (int i = 0; i <= TO; i++) step($sformatf("to_wr_busy%0d", i), busy(0, 8'h00, 1, 3'd7, 8'h77));
      step("to_wr_done", idle(0, 8'h00, 0, 2'b00, 32'h0, 1));
      step("to_wr_after", idle(0, 8'h00, 0, 2'b00, 32'h0, 0));

      // Reset asserted mid-read: outputs clear at once, no late completion.
      step("rst_req", mk(1, 0, 5'h18, 32'h0, 4'h0, 0, 8'h0, 0, 0, 3'd0, 8'h0, 0, 2'b00, 32'h0, 0));
      step("rst_busy", busy(0, 8'h00, 0, 3'd6, 8'h0));
      @(posedge clk); #1;
      #1 rst_in = 1'b0;
      #1 check_reset_outs("rst_async");
      @(posedge clk); #1;
      rst_in = 1'b1;
      wb_if.wbm_ack_i = 1'b1;
      @(negedge clk);
      check_outs("rst_rel0", idle(1, 8'h00, 0, 2'b00, 32'h0, 0));
      for (int i = 1; i < 4; i++) step($sformatf("rst_rel%0d", i), idle(1, 8'h11, 0, 2'b00, 32'h0, 0));
      last_rdata = 32'h0;

      for (int t = 0; t < 80; t++) run_txn(t);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
